// File: rtl/imm_encoder_if.sv
// -----------------------------------------------------------------------------
// imm_encoder_if
// Request/response bundle for the immediate encoder.
//   Request side : in_valid, in_ready, imm_sel[2:0], imm[WIDTH-1:0],
//                  base_instr[WIDTH-1:0]
//   Response side: out_valid, out_ready, instr[WIDTH-1:0], range_err,
//                  err_count[7:0]
// Modports:
//   master - the agent that issues requests and consumes results
//   slave  - the encoder itself
// -----------------------------------------------------------------------------
interface imm_encoder_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       imm_sel;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] base_instr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] instr;
  logic             range_err;
  logic [7:0]       err_count;

  modport master (
    output in_valid, imm_sel, imm, base_instr, out_ready,
    input  in_ready, out_valid, instr, range_err, err_count
  );

  modport slave (
    input  in_valid, imm_sel, imm, base_instr, out_ready,
    output in_ready, out_valid, instr, range_err, err_count
  );
endinterface

// File: rtl/imm_encoder.sv
// -----------------------------------------------------------------------------
// imm_encoder
// Two-stage pipeline that merges a signed immediate into a RISC-V style base
// instruction for the I, S, SB, U and UJ formats. Immediate bit positions of
// base_instr are overwritten; every other bit passes through unchanged.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - imm_encoder_if.slave (valid/ready request in, valid/ready result
//          out, range_err flag and saturating err_count)
//
// Configuration:
//   IMM_ENCODER_RANGE_CHECK_EN - when defined, immediates that do not fit the
//   selected format (and unsupported imm_sel codes) raise range_err and are
//   counted in err_count. When undefined both outputs are tied to 0; encoding
//   and timing are identical.
//
// Only WIDTH = 32 is supported; the format bit positions are fixed.
// -----------------------------------------------------------------------------
module imm_encoder #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  imm_encoder_if.slave bus
);

  localparam logic [2:0] SEL_I  = 3'b000;
  localparam logic [2:0] SEL_S  = 3'b001;
  localparam logic [2:0] SEL_SB = 3'b010;
  localparam logic [2:0] SEL_U  = 3'b011;
  localparam logic [2:0] SEL_UJ = 3'b100;

  // Overlay the immediate onto base; on overflow the high bits are simply
  // dropped. Unknown selectors return base untouched.
  function automatic logic [WIDTH-1:0] encode_imm(
    input logic [2:0]              sel,
    input logic signed [WIDTH-1:0] imm,
    input logic [WIDTH-1:0]        base
  );
    logic [WIDTH-1:0] enc;
    enc = base;
    case (sel)
      SEL_I:   enc = {imm[11:0], base[19:0]};
      SEL_S:   enc = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
      SEL_SB:  enc = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
      SEL_U:   enc = {imm[31:12], base[11:0]};
      SEL_UJ:  enc = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
      default: enc = base;
    endcase
    return enc;
  endfunction

`ifdef IMM_ENCODER_RANGE_CHECK_EN
  // A value fits an N-bit signed field when all bits above the field's sign
  // bit replicate it, i.e. the upper slice is all zeros or all ones.
  function automatic logic range_fail(
    input logic [2:0]              sel,
    input logic signed [WIDTH-1:0] imm
  );
    logic fail;
    fail = 1'b1;
    case (sel)
      SEL_I, SEL_S: fail = !((&imm[31:11]) || !(|imm[31:11]));
      SEL_SB:       fail = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      SEL_U:        fail = |imm[11:0];
      SEL_UJ:       fail = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      default:      fail = 1'b1;
    endcase
    return fail;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction
`endif

  logic                    r_vld_p1;
  logic [2:0]              r_sel_p1;
  logic signed [WIDTH-1:0] r_imm_p1;
  logic [WIDTH-1:0]        r_base_p1;
  logic                    r_vld_p2;
  logic [WIDTH-1:0]        r_instr_p2;

  logic                    w_in_ready;
  logic                    w_in_xfer;
  logic                    w_adv_p1;
  logic [WIDTH-1:0]        w_instr_p1;

  // S2 can take a new word when it is empty or being drained this cycle.
  // Input is refused only when both stages are full and the output stalls.
  assign w_adv_p1   = !r_vld_p2 || bus.out_ready;
  assign w_in_ready = !(r_vld_p1 && r_vld_p2 && !bus.out_ready);
  assign w_in_xfer  = bus.in_valid && w_in_ready;
  assign w_instr_p1 = encode_imm(r_sel_p1, r_imm_p1, r_base_p1);

  // ---- Stage 1: capture request ----
  always_ff @(posedge clk) begin
    if (w_in_xfer) begin
      r_sel_p1  <= bus.imm_sel;
      r_imm_p1  <= bus.imm;
      r_base_p1 <= bus.base_instr;
    end
  end

  // ---- Stage 2: encoded result ----
  // instr is reset too so no stale word is ever visible after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1   <= 1'b0;
      r_vld_p2   <= 1'b0;
      r_instr_p2 <= '0;
    end else begin
      // S1 is either empty or moving on whenever input is ready.
      if (w_in_ready) begin
        r_vld_p1 <= bus.in_valid;
      end
      if (w_adv_p1) begin
        r_vld_p2 <= r_vld_p1;
        if (r_vld_p1) begin
          r_instr_p2 <= w_instr_p1;
        end
      end
    end
  end

`ifdef IMM_ENCODER_RANGE_CHECK_EN
  logic       r_err_p2;
  logic [7:0] r_err_cnt;
  logic       w_err_p1;
  logic       w_out_xfer;

  assign w_err_p1   = range_fail(r_sel_p1, r_imm_p1);
  assign w_out_xfer = r_vld_p2 && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_p2  <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      if (w_adv_p1 && r_vld_p1) begin
        r_err_p2 <= w_err_p1;
      end
      if (w_out_xfer && r_err_p2) begin
        r_err_cnt <= sat_inc8(r_err_cnt);
      end
    end
  end

  assign bus.range_err = r_err_p2;
  assign bus.err_count = r_err_cnt;
`else
  assign bus.range_err = 1'b0;
  assign bus.err_count = 8'd0;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_vld_p2;
  assign bus.instr     = r_instr_p2;

endmodule

// File: tb/tb_imm_encoder.sv
// -----------------------------------------------------------------------------
// tb_imm_encoder
// Self-checking bench for imm_encoder: directed vector table, back-pressure
// and reset sequences, a saturation run and a randomized stream, all checked
// against a reference model that derives encodings with shifts/masks and
// range checks with signed numeric bounds.
// -----------------------------------------------------------------------------
module tb_imm_encoder;
  localparam int WIDTH = 32;
`ifdef IMM_ENCODER_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  imm_encoder_if #(.WIDTH(WIDTH)) u_if ();

  imm_encoder #(.WIDTH(WIDTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_tests   = 0;
  int          n_fail    = 0;
  int          model_cnt = 0;
  int          n_out     = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_instr;
  logic        prev_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: place fields with shifts/masks, judge range numerically.
  function automatic exp_t ref_model(input logic [2:0] sel, input logic [31:0] imm,
                                     input logic [31:0] base);
    exp_t e;
    int   v;
    bit   odd;
    v   = $signed(imm);
    odd = (imm & 32'h1) != 0;
    case (sel)
      3'd0: begin
        e.instr = (base & 32'h000FFFFF) | ((imm & 32'hFFF) << 20);
        e.err   = (v < -2048) || (v > 2047);
      end
      3'd1: begin
        e.instr = (base & ~32'hFE000F80) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
        e.err   = (v < -2048) || (v > 2047);
      end
      3'd2: begin
        e.instr = (base & ~32'hFE000F80) | (((imm >> 12) & 32'h1) << 31) |
                  (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8) |
                  (((imm >> 11) & 32'h1) << 7);
        e.err   = (v < -4096) || (v > 4095) || odd;
      end
      3'd3: begin
        e.instr = (base & 32'h00000FFF) | (imm & 32'hFFFFF000);
        e.err   = (imm % 4096) != 0;
      end
      3'd4: begin
        e.instr = (base & 32'h00000FFF) | (((imm >> 20) & 32'h1) << 31) |
                  (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20) |
                  (imm & 32'h000FF000);
        e.err   = (v < -1048576) || (v > 1048575) || odd;
      end
      default: begin
        e.instr = base;
        e.err   = 1'b1;
      end
    endcase
    if (!RC) e.err = 1'b0;
    return e;
  endfunction

  // Scoreboard: every accepted request is delivered once, in order.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", u_if.out_valid, 1);
        chk("hold_instr", u_if.instr, prev_instr);
        chk("hold_err", u_if.range_err, prev_err);
      end
      chk("in_ready", u_if.in_ready, !(exp_q.size() == 2 && !u_if.out_ready));
      chk("err_count", u_if.err_count, model_cnt);
      if (u_if.out_valid && u_if.out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_out: got 0x%08h, expected no output at %0t", u_if.instr, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_instr", u_if.instr, mon_e.instr);
          chk("out_err", u_if.range_err, mon_e.err);
          if (mon_e.err && model_cnt < 255) model_cnt++;
          n_out++;
        end
      end
      if (u_if.in_valid && u_if.in_ready)
        exp_q.push_back(ref_model(u_if.imm_sel, u_if.imm, u_if.base_instr));
      prev_stall = u_if.out_valid && !u_if.out_ready;
      prev_instr = u_if.instr;
      prev_err   = u_if.range_err;
    end
  end

  task automatic send(input logic [2:0] sel, input logic [31:0] imm, input logic [31:0] base);
    bit acc;
    acc = 1'b0;
    u_if.in_valid   = 1'b1;
    u_if.imm_sel    = sel;
    u_if.imm        = imm;
    u_if.base_instr = base;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = u_if.in_ready;
      @(posedge clk);
      #1;
    end
    u_if.in_valid = 1'b0;
    chk("send_accepted", acc, 1);
  endtask

  task automatic wait_out(output int edges);
    edges = 0;
    while (!u_if.out_valid && edges < 50) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic bp_req(input int k);
    u_if.imm_sel    = 3'd0;
    u_if.imm        = 32'h10 * (k + 1);
    u_if.base_instr = 32'h13 | (k << 7);
  endtask

  task automatic rand_req();
    int mode;
    int v;
    u_if.in_valid   = ($urandom_range(0, 4) != 0);
    u_if.imm_sel    = 3'($urandom_range(0, 7));
    u_if.base_instr = $urandom;
    mode = $urandom_range(0, 3);
    case (mode)
      0: u_if.imm = $urandom;
      1: begin v = int'($urandom_range(0, 8191)) - 4096; u_if.imm = v; end
      2: u_if.imm = $urandom << 12;
      default: begin v = int'($urandom_range(0, 2097151)) - 1048576; u_if.imm = v; end
    endcase
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  vec_t vt[13];
  int   edges;
  int   acc;
  int   n0;
  bit   last_acc;

  initial begin
    vt[0]  = '{3'd0, 32'hFFFFFFFF, 32'h00000013, 32'hFFF00013, 1'b0};
    vt[1]  = '{3'd2, 32'hFFFFFFFC, 32'h00000063, 32'hFE000EE3, 1'b0};
    vt[2]  = '{3'd4, 32'h00000800, 32'h0000006F, 32'h0010006F, 1'b0};
    vt[3]  = '{3'd0, 32'h00000800, 32'h00000013, 32'h80000013, 1'b1};
    vt[4]  = '{3'd1, 32'h0000007C, 32'h00002023, 32'h06002E23, 1'b0};
    vt[5]  = '{3'd3, 32'h12345000, 32'h00000537, 32'h12345537, 1'b0};
    vt[6]  = '{3'd3, 32'h12345678, 32'h00000037, 32'h12345037, 1'b1};
    vt[7]  = '{3'd5, 32'h00000001, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1};
    vt[8]  = '{3'd2, 32'h00000003, 32'h00000063, 32'h00000163, 1'b1};
    vt[9]  = '{3'd4, 32'hFFF00000, 32'h0000006F, 32'h8000006F, 1'b0};
    vt[10] = '{3'd4, 32'h00100000, 32'h0000006F, 32'h8000006F, 1'b1};
    vt[11] = '{3'd0, 32'hFFFFF800, 32'h00000013, 32'h80000013, 1'b0};
    vt[12] = '{3'd0, 32'h00000000, 32'hFFFFFFFF, 32'h000FFFFF, 1'b0};

    u_if.in_valid   = 1'b0;
    u_if.imm_sel    = 3'd0;
    u_if.imm        = '0;
    u_if.base_instr = '0;
    u_if.out_ready  = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", u_if.out_valid, 0);
    chk("rst_instr", u_if.instr, 0);
    chk("rst_range_err", u_if.range_err, 0);
    chk("rst_err_count", u_if.err_count, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", u_if.in_ready, 1);
    @(posedge clk);
    #1;

    // Directed vectors, one at a time, with latency check
    for (int i = 0; i < 13; i++) begin
      send(vt[i].sel, vt[i].imm, vt[i].base);
      wait_out(edges);
      chk($sformatf("vec%0d_latency", i), edges + 1, 2);
      chk($sformatf("vec%0d_instr", i), u_if.instr, vt[i].instr);
      chk($sformatf("vec%0d_err", i), u_if.range_err, vt[i].err & RC);
      @(posedge clk);
      #1;
    end
    chk("err_count_table", u_if.err_count, RC ? 5 : 0);

    // Saturation: 300 back-to-back out-of-range I-type requests
    u_if.imm_sel    = 3'd0;
    u_if.imm        = 32'h00000800;
    u_if.base_instr = 32'h00000013;
    u_if.in_valid   = 1'b1;
    acc = 0;
    for (int c = 0; c < 1000 && acc < 300; c++) begin
      @(negedge clk);
      if (u_if.in_ready) acc++;
      @(posedge clk);
      #1;
      if (acc == 300) u_if.in_valid = 1'b0;
    end
    u_if.in_valid = 1'b0;
    chk("sat_accepted", acc, 300);
    repeat (4) @(posedge clk);
    #1;
    chk("err_count_sat", u_if.err_count, RC ? 255 : 0);

    // Back-pressure: 4 requests, output stalled for 5 cycles
    n0 = n_out;
    u_if.out_ready = 1'b0;
    acc = 0;
    bp_req(0);
    u_if.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (u_if.in_ready) acc++;
      @(posedge clk);
      #1;
      bp_req(acc);
    end
    chk("bp_accepted", acc, 2);
    chk("bp_in_ready", u_if.in_ready, 0);
    u_if.out_ready = 1'b1;
    for (int c = 0; c < 50 && acc < 4; c++) begin
      @(negedge clk);
      if (u_if.in_ready) acc++;
      @(posedge clk);
      #1;
      if (acc >= 4) u_if.in_valid = 1'b0;
      else bp_req(acc);
    end
    u_if.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_delivered", n_out - n0, 4);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Randomized stream with random back-pressure
    last_acc = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (!u_if.in_valid || last_acc) rand_req();
      u_if.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      last_acc = u_if.in_valid && u_if.in_ready;
      @(posedge clk);
      #1;
    end
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rand_drain", exp_q.size(), 0);

    // Reset while both stages hold data
    u_if.out_ready  = 1'b0;
    u_if.imm_sel    = 3'd0;
    u_if.imm        = 32'h00000800;
    u_if.base_instr = 32'h00000013;
    u_if.in_valid   = 1'b1;
    acc = 0;
    for (int c = 0; c < 20 && acc < 2; c++) begin
      @(negedge clk);
      if (u_if.in_ready) acc++;
      @(posedge clk);
      #1;
    end
    u_if.in_valid = 1'b0;
    chk("rst_mid_pre_valid", u_if.out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", u_if.out_valid, 0);
    chk("rst_mid_err_count", u_if.err_count, 0);
    chk("rst_mid_instr", u_if.instr, 0);
    chk("rst_mid_range_err", u_if.range_err, 0);
    exp_q.delete();
    model_cnt = 0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_mid_in_ready", u_if.in_ready, 1);
    chk("rst_mid_idle", u_if.out_valid, 0);
    u_if.out_ready = 1'b1;
    send(3'd1, 32'h0000007C, 32'h00002023);
    wait_out(edges);
    chk("rst_mid_latency", edges + 1, 2);
    chk("rst_mid_first_instr", u_if.instr, 32'h06002E23);
    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
